commit_buffer: RTL and testbench
================================

Name: commit_buffer

Overview:
- In-order retirement buffer that receives the two per-cycle execute-stage results and retires them in program order.
- Dispatch allocates entries and receives tags. Writeback marks entries done and stores their results.
- Commit retires up to 2 done entries per cycle to the register file.
- An established branch discards every younger entry and issues a PC redirect.

Parameters:
DEPTH_LOG, 3, log2 of entry count (8 entries); tag = {phase bit, index}, width DEPTH_LOG+1
XLEN, 32, data width

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
alloc_valid[2]  input  1  dispatch allocation request per lane
alloc_rd[2]  input  5  destination register of allocated instruction
alloc_ready  output  1  at least 2 entries free (registered count)
alloc_tag[2]  output  DEPTH_LOG+1  tags granted to lane 0 / lane 1 this cycle
wb_valid[2]  input  1  execute result valid per lane
wb_tag[2]  input  DEPTH_LOG+1  tag of result
wb_result[2]  input  XLEN  result value
wb_branch_taken[2]  input  1  branch established for this result
wb_jumped_to[2]  input  XLEN  branch target
commit_valid[2]  output  1  entry retiring this cycle
commit_rd[2]  output  5  destination register
commit_value[2]  output  XLEN  value to write
redirect_valid  output  1  flush performed, fetch must restart
redirect_pc  output  XLEN  restart address
is_tag_flooded  output  1  tail phase bit differs from head phase bit (buffer wrapped)
count  output  DEPTH_LOG+1  occupied entries

Behaviour:
- Reset (async) state: head=tail=0, count=0, all valid/done bits cleared.
- Reset output values: commit_valid=0, redirect_valid=0, redirect_pc=0, alloc_ready=1, is_tag_flooded=0.
- Entry fields: valid, done, rd, value.
- Allocation:
  - alloc_tag[0]=tail, alloc_tag[1]=tail+1, always driven combinationally.
  - Lane 0 is accepted only if alloc_ready. Lane 1 is accepted only if lane 0 is also accepted; alloc_valid[1] alone is ignored.
  - Tail advances by the number accepted. Tag arithmetic wraps modulo 2^(DEPTH_LOG+1).
- Writeback:
  - A valid writeback to a valid entry whose index matches sets done and stores the value at the edge.
  - A writeback to an invalid entry is ignored.
  - Both lanes may write in the same cycle to distinct entries.
- Commit:
  - commit_valid[0] = head entry valid & done. commit_valid[1] = commit_valid[0] & (head+1) valid & done.
  - commit outputs are combinational from registered state; head and count update at the edge.
  - Latency: writeback at edge N means the entry is retireable in cycle N+1.
- Flush:
  - A writeback with wb_branch_taken to a valid entry is a flush. If both lanes flush, the older one wins, where age = (tag - head) mod 2^(DEPTH_LOG+1).
  - At the edge: the branch entry is marked done, all entries younger than it are invalidated, tail = branch tag + 1, and count is recomputed.
  - redirect_valid=1 and redirect_pc=target for exactly one cycle after the edge (registered).
  - A writeback in the same cycle to an entry younger than the branch is dropped.
  - Allocation in the flush cycle is dropped.
  - Commit in the flush cycle proceeds normally.
- is_tag_flooded = head[DEPTH_LOG] != tail[DEPTH_LOG]. It is combinational and must match the tag MSB convention of the execute stage.
- Full: count==2^DEPTH_LOG, so alloc_ready=0. Empty: count==0, so commit_valid=0.
- Simultaneous alloc and commit: count = count + allocated - committed. alloc_ready reflects only the registered count.
- Reset mid-operation clears everything in the same instant. Reset must not produce a redirect or a commit.

Optional Feature:
- Macro COMMIT_BUFFER_PERF_EN.
- When defined: output perf_committed (32 bits) counts retired entries and perf_flushes (32 bits) counts flushes. Both wrap modulo 2^32 and reset to 0.
- When undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> count=0, alloc_ready=1, commit_valid=00, redirect_valid=0.
- Allocate 2 (rd 5, 6), wb tag1=0x22, then tag0=0x11 a cycle later -> nothing commits until tag0 is done; then both commit in one cycle with values 0x11 and 0x22, count returns to 0.
- Allocate 8 entries -> alloc_ready=0, is_tag_flooded tracks the phase. Further alloc_valid is ignored and the tail is unchanged.
- 4 entries allocated; wb tag1 with branch_taken, target 0x100 -> next cycle redirect_valid=1, redirect_pc=0x100; entries 2 and 3 invalid; count=2.
- Both lanes flush in one cycle (tags 3 and 1, head 0) -> tag 1 wins; tail=2.
- Assert reset while 5 entries are pending -> all outputs at reset values immediately, with no stale commit after release.

Source files
------------

// File: rtl/commit_buffer.sv
// In-order dual-lane commit buffer: allocate at tail, complete by tag, retire up to two per cycle.
// Optional perf counters are built in when COMMIT_BUFFER_PERF_EN is defined.
module commit_buffer #(
    parameter int unsigned DEPTH_LOG = 3,
    parameter int unsigned XLEN      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           alloc_valid_i,
    input  logic [4:0]           alloc_rd0_i,
    input  logic [4:0]           alloc_rd1_i,
    output logic                 alloc_ready_o,
    output logic [DEPTH_LOG:0]   alloc_tag0_o,
    output logic [DEPTH_LOG:0]   alloc_tag1_o,
    input  logic [1:0]           wb_valid_i,
    input  logic [DEPTH_LOG:0]   wb_tag0_i,
    input  logic [DEPTH_LOG:0]   wb_tag1_i,
    input  logic [XLEN-1:0]      wb_result0_i,
    input  logic [XLEN-1:0]      wb_result1_i,
    input  logic [1:0]           wb_branch_taken_i,
    input  logic [XLEN-1:0]      wb_jumped_to0_i,
    input  logic [XLEN-1:0]      wb_jumped_to1_i,
    output logic [1:0]           commit_valid_o,
    output logic [4:0]           commit_rd0_o,
    output logic [4:0]           commit_rd1_o,
    output logic [XLEN-1:0]      commit_value0_o,
    output logic [XLEN-1:0]      commit_value1_o,
    output logic                 redirect_valid_o,
    output logic [XLEN-1:0]      redirect_pc_o,
    output logic                 is_tag_flooded_o,
`ifdef COMMIT_BUFFER_PERF_EN
    output logic [31:0]          perf_committed_o,
    output logic [31:0]          perf_flushes_o,
`endif
    output logic [DEPTH_LOG:0]   count_o
);
    localparam int unsigned Depth = 2 ** DEPTH_LOG;

    typedef logic [DEPTH_LOG:0]   tag_t;
    typedef logic [DEPTH_LOG-1:0] idx_t;

    tag_t             head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [Depth-1:0] valid_q, valid_d, done_q, done_d;
    logic [4:0]       rd_q    [Depth];
    logic [4:0]       rd_d    [Depth];
    logic [XLEN-1:0]  value_q [Depth];
    logic [XLEN-1:0]  value_d [Depth];
    logic             redirect_valid_q;
    logic [XLEN-1:0]  redirect_pc_q;

    tag_t            wb_tag    [2];
    logic [XLEN-1:0] wb_result [2];
    logic [XLEN-1:0] wb_target [2];

    assign wb_tag[0]    = wb_tag0_i;
    assign wb_tag[1]    = wb_tag1_i;
    assign wb_result[0] = wb_result0_i;
    assign wb_result[1] = wb_result1_i;
    assign wb_target[0] = wb_jumped_to0_i;
    assign wb_target[1] = wb_jumped_to1_i;

    idx_t head_idx, head_idx1, tail_idx, tail_idx1;
    assign head_idx  = head_q[DEPTH_LOG-1:0];
    assign head_idx1 = head_idx + idx_t'(1);
    assign tail_idx  = tail_q[DEPTH_LOG-1:0];
    assign tail_idx1 = tail_idx + idx_t'(1);

    logic [1:0] commit_v;
    assign commit_v[0] = valid_q[head_idx] & done_q[head_idx];
    assign commit_v[1] = commit_v[0] & valid_q[head_idx1] & done_q[head_idx1];

    // Ages are index distances from head; a live entry is always fewer than Depth slots away.
    idx_t       wb_age [2];
    logic [1:0] wb_hit, wb_flush;
    always_comb begin
        wb_hit    = '0;
        wb_flush  = '0;
        wb_age[0] = '0;
        wb_age[1] = '0;
        for (int l = 0; l < 2; l++) begin
            wb_hit[l]   = wb_valid_i[l] & valid_q[wb_tag[l][DEPTH_LOG-1:0]];
            wb_flush[l] = wb_hit[l] & wb_branch_taken_i[l];
            wb_age[l]   = wb_tag[l][DEPTH_LOG-1:0] - head_idx;
        end
    end

    logic            flush, br_lane;
    idx_t            br_age;
    tag_t            br_tag;
    logic [XLEN-1:0] br_target;
    assign flush     = |wb_flush;
    assign br_lane   = wb_flush[1] & (~wb_flush[0] | (wb_age[1] < wb_age[0]));
    assign br_age    = wb_age[br_lane];
    assign br_tag    = wb_tag[br_lane];
    assign br_target = wb_target[br_lane];

    logic acc0, acc1;
    assign alloc_ready_o = count_q <= tag_t'(Depth - 2);
    assign acc0          = alloc_valid_i[0] & alloc_ready_o & ~flush;
    assign acc1          = acc0 & alloc_valid_i[1];

    idx_t ent_age;
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rd_d    = rd_q;
        value_d = value_q;
        ent_age = '0;
        // Results for entries younger than the winning branch are squashed with them.
        for (int l = 0; l < 2; l++) begin
            if (wb_hit[l] && (!flush || wb_age[l] <= br_age)) begin
                done_d[wb_tag[l][DEPTH_LOG-1:0]]  = 1'b1;
                value_d[wb_tag[l][DEPTH_LOG-1:0]] = wb_result[l];
            end
        end
        if (acc0) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            rd_d[tail_idx]    = alloc_rd0_i;
        end
        if (acc1) begin
            valid_d[tail_idx1] = 1'b1;
            done_d[tail_idx1]  = 1'b0;
            rd_d[tail_idx1]    = alloc_rd1_i;
        end
        if (flush) begin
            for (int i = 0; i < int'(Depth); i++) begin
                ent_age = idx_t'(i) - head_idx;
                if (ent_age > br_age) begin
                    valid_d[i] = 1'b0;
                    done_d[i]  = 1'b0;
                end
            end
        end
        if (commit_v[0]) valid_d[head_idx] = 1'b0;
        if (commit_v[1]) valid_d[head_idx1] = 1'b0;
    end

    assign head_d  = head_q + tag_t'(commit_v[0]) + tag_t'(commit_v[1]);
    assign tail_d  = flush ? br_tag + tag_t'(1) : tail_q + tag_t'(acc0) + tag_t'(acc1);
    assign count_d = tail_d - head_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            valid_q          <= '0;
            done_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            valid_q          <= valid_d;
            done_q           <= done_d;
            redirect_valid_q <= flush;
            if (flush) redirect_pc_q <= br_target;
        end
    end

    // Payload needs no reset: it is only observed through valid/done.
    always_ff @(posedge clk_i) begin
        rd_q    <= rd_d;
        value_q <= value_d;
    end

`ifdef COMMIT_BUFFER_PERF_EN
    logic [31:0] perf_committed_q, perf_flushes_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_committed_q <= '0;
            perf_flushes_q   <= '0;
        end else begin
            perf_committed_q <= perf_committed_q + 32'(commit_v[0]) + 32'(commit_v[1]);
            perf_flushes_q   <= perf_flushes_q + 32'(flush);
        end
    end
    assign perf_committed_o = perf_committed_q;
    assign perf_flushes_o   = perf_flushes_q;
`endif

    assign alloc_tag0_o     = tail_q;
    assign alloc_tag1_o     = tail_q + tag_t'(1);
    assign commit_valid_o   = commit_v;
    assign commit_rd0_o     = rd_q[head_idx];
    assign commit_rd1_o     = rd_q[head_idx1];
    assign commit_value0_o  = value_q[head_idx];
    assign commit_value1_o  = value_q[head_idx1];
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign is_tag_flooded_o = head_q[DEPTH_LOG] ^ tail_q[DEPTH_LOG];
    assign count_o          = count_q;
endmodule

// File: tb/tb_commit_buffer.sv
// Bench for commit_buffer: directed vector table, flush/reset sequences, random vs queue model.
module tb_commit_buffer;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  av, wv, wbr;
    logic [4:0]  ard [2];
    logic [3:0]  wt  [2];
    logic [31:0] wr  [2];
    logic [31:0] wj  [2];

    logic        ready, redir, flood;
    logic [3:0]  tag0, tag1, cnt;
    logic [1:0]  cv;
    logic [4:0]  crd0, crd1;
    logic [31:0] cval0, cval1, rpc;
`ifdef COMMIT_BUFFER_PERF_EN
    logic [31:0] perf_c, perf_f;
`endif

    commit_buffer #(.DEPTH_LOG(3), .XLEN(32)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .alloc_valid_i     (av),
        .alloc_rd0_i       (ard[0]),
        .alloc_rd1_i       (ard[1]),
        .alloc_ready_o     (ready),
        .alloc_tag0_o      (tag0),
        .alloc_tag1_o      (tag1),
        .wb_valid_i        (wv),
        .wb_tag0_i         (wt[0]),
        .wb_tag1_i         (wt[1]),
        .wb_result0_i      (wr[0]),
        .wb_result1_i      (wr[1]),
        .wb_branch_taken_i (wbr),
        .wb_jumped_to0_i   (wj[0]),
        .wb_jumped_to1_i   (wj[1]),
        .commit_valid_o    (cv),
        .commit_rd0_o      (crd0),
        .commit_rd1_o      (crd1),
        .commit_value0_o   (cval0),
        .commit_value1_o   (cval1),
        .redirect_valid_o  (redir),
        .redirect_pc_o     (rpc),
        .is_tag_flooded_o  (flood),
`ifdef COMMIT_BUFFER_PERF_EN
        .perf_committed_o  (perf_c),
        .perf_flushes_o    (perf_f),
`endif
        .count_o           (cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: program-ordered queue of live entries, oldest first.
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic        done;
        logic [31:0] val;
    } ent_t;
    ent_t        q[$];
    logic [3:0]  mhead;
    logic        exp_redir;
    logic [31:0] exp_pc;

    task automatic idle();
        av = '0; wv = '0; wbr = '0;
        for (int l = 0; l < 2; l++) begin
            ard[l] = '0; wt[l] = '0; wr[l] = '0; wj[l] = '0;
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        mhead = '0;
        exp_redir = 1'b0;
        exp_pc = '0;
    endtask

    task automatic check_state();
        int sz;
        logic [3:0] tl;
        logic e0, e1;
        sz = q.size();
        tl = mhead + 4'(sz);
        e0 = (sz > 0) && q[0].done;
        e1 = e0 && (sz > 1) && q[1].done;
        chk("count", 64'(cnt), 64'(sz));
        chk("alloc_ready", 64'(ready), 64'(sz <= D - 2));
        chk("alloc_tag0", 64'(tag0), 64'(tl));
        chk("alloc_tag1", 64'(tag1), 64'(4'(tl + 4'd1)));
        chk("is_tag_flooded", 64'(flood), 64'(mhead[3] != tl[3]));
        chk("commit_valid", 64'(cv), 64'({e1, e0}));
        if (e0) begin
            chk("commit_rd0", 64'(crd0), 64'(q[0].rd));
            chk("commit_value0", 64'(cval0), 64'(q[0].val));
        end
        if (e1) begin
            chk("commit_rd1", 64'(crd1), 64'(q[1].rd));
            chk("commit_value1", 64'(cval1), 64'(q[1].val));
        end
        chk("redirect_valid", 64'(redir), 64'(exp_redir));
        if (exp_redir) chk("redirect_pc", 64'(rpc), 64'(exp_pc));
    endtask

    task automatic model_step();
        int sz0, n, bp, bl;
        int pos [2];
        ent_t e;
        sz0 = q.size();
        n = 0;
        if (sz0 > 0 && q[0].done) n = 1;
        if (n == 1 && sz0 > 1 && q[1].done) n = 2;
        bp = -1;
        bl = 0;
        for (int l = 0; l < 2; l++) begin
            pos[l] = -1;
            if (wv[l]) begin
                for (int p = 0; p < sz0; p++) if (q[p].tag[2:0] == wt[l][2:0]) pos[l] = p;
            end
        end
        for (int l = 0; l < 2; l++)
            if (pos[l] >= 0 && wbr[l] && (bp < 0 || pos[l] < bp)) begin
                bp = pos[l];
                bl = l;
            end
        for (int l = 0; l < 2; l++)
            if (pos[l] >= 0 && (bp < 0 || pos[l] <= bp)) begin
                e = q[pos[l]];
                e.done = 1'b1;
                e.val = wr[l];
                q[pos[l]] = e;
            end
        exp_redir = (bp >= 0);
        if (bp >= 0) begin
            exp_pc = wj[bl];
            while (q.size() > bp + 1) void'(q.pop_back());
        end else if (av[0] && sz0 <= D - 2) begin
            for (int l = 0; l < 2; l++)
                if (l == 0 || av[1]) begin
                    e.tag = mhead + 4'(sz0 + l);
                    e.rd = ard[l];
                    e.done = 1'b0;
                    e.val = '0;
                    q.push_back(e);
                end
        end
        for (int i = 0; i < n; i++) void'(q.pop_front());
        mhead = mhead + 4'(n);
    endtask

    task automatic rand_drive();
        int sz, k;
        int cand[$];
        sz = q.size();
        av = 2'($urandom_range(0, 3));
        ard[0] = 5'($urandom);
        ard[1] = 5'($urandom);
        for (int p = 0; p < sz; p++) if (!q[p].done) cand.push_back(p);
        wv = '0;
        wbr = '0;
        for (int l = 0; l < 2; l++) begin
            wr[l] = $urandom;
            wj[l] = $urandom;
            wt[l] = '0;
            wbr[l] = ($urandom_range(0, 7) == 0);
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, cand.size() - 1);
                wt[l] = q[cand[k]].tag;
                wv[l] = 1'b1;
                cand.delete(k);
            end else if (sz < D && $urandom_range(0, 3) == 0) begin
                // Tag of a free slot: must be ignored.
                wt[l] = mhead + 4'(sz) + 4'($urandom_range(0, D - 1 - sz));
                wv[l] = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  av;
        logic        wv;
        logic [3:0]  wt;
        logic [31:0] wr;
        logic [3:0]  e_cnt;
        logic        e_rdy;
        logic [3:0]  e_tag0;
        logic        e_flood;
        logic [1:0]  e_cv;
        logic [31:0] e_v0;
        logic [31:0] e_v1;
    } vec_t;
    vec_t tbl [12];

    initial begin
        tbl[0]  = '{2'b11, 1'b0, 4'd0, 32'h00, 4'd0, 1'b1, 4'd0,  1'b0, 2'b00, 32'h0,  32'h0};
        tbl[1]  = '{2'b00, 1'b1, 4'd1, 32'h22, 4'd2, 1'b1, 4'd2,  1'b0, 2'b00, 32'h0,  32'h0};
        tbl[2]  = '{2'b00, 1'b1, 4'd0, 32'h11, 4'd2, 1'b1, 4'd2,  1'b0, 2'b00, 32'h0,  32'h0};
        tbl[3]  = '{2'b00, 1'b0, 4'd0, 32'h00, 4'd2, 1'b1, 4'd2,  1'b0, 2'b11, 32'h11, 32'h22};
        tbl[4]  = '{2'b10, 1'b0, 4'd0, 32'h00, 4'd0, 1'b1, 4'd2,  1'b0, 2'b00, 32'h0,  32'h0};
        tbl[5]  = '{2'b11, 1'b0, 4'd0, 32'h00, 4'd0, 1'b1, 4'd2,  1'b0, 2'b00, 32'h0,  32'h0};
        tbl[6]  = '{2'b11, 1'b0, 4'd0, 32'h00, 4'd2, 1'b1, 4'd4,  1'b0, 2'b00, 32'h0,  32'h0};
        tbl[7]  = '{2'b11, 1'b0, 4'd0, 32'h00, 4'd4, 1'b1, 4'd6,  1'b0, 2'b00, 32'h0,  32'h0};
        tbl[8]  = '{2'b11, 1'b0, 4'd0, 32'h00, 4'd6, 1'b1, 4'd8,  1'b1, 2'b00, 32'h0,  32'h0};
        tbl[9]  = '{2'b11, 1'b0, 4'd0, 32'h00, 4'd8, 1'b0, 4'd10, 1'b1, 2'b00, 32'h0,  32'h0};
        tbl[10] = '{2'b01, 1'b0, 4'd0, 32'h00, 4'd8, 1'b0, 4'd10, 1'b1, 2'b00, 32'h0,  32'h0};
        tbl[11] = '{2'b00, 1'b0, 4'd0, 32'h00, 4'd8, 1'b0, 4'd10, 1'b1, 2'b00, 32'h0,  32'h0};

        do_reset();
        check_state();

        // Directed table: out-of-order completion, paired retire, fill to full.
        for (int i = 0; i < 12; i++) begin
            chk("tbl_count", 64'(cnt), 64'(tbl[i].e_cnt));
            chk("tbl_alloc_ready", 64'(ready), 64'(tbl[i].e_rdy));
            chk("tbl_alloc_tag0", 64'(tag0), 64'(tbl[i].e_tag0));
            chk("tbl_flooded", 64'(flood), 64'(tbl[i].e_flood));
            chk("tbl_commit_valid", 64'(cv), 64'(tbl[i].e_cv));
            if (tbl[i].e_cv[1]) begin
                chk("tbl_commit_value0", 64'(cval0), 64'(tbl[i].e_v0));
                chk("tbl_commit_value1", 64'(cval1), 64'(tbl[i].e_v1));
                chk("tbl_commit_rd0", 64'(crd0), 64'd5);
                chk("tbl_commit_rd1", 64'(crd1), 64'd6);
            end
            av = tbl[i].av;
            ard[0] = 5'd5;
            ard[1] = 5'd6;
            wv = {1'b0, tbl[i].wv};
            wt[0] = tbl[i].wt;
            wr[0] = tbl[i].wr;
            @(negedge clk);
        end

        // Single flush: branch at tag 1 squashes tags 2 and 3.
        do_reset();
        av = 2'b11;
        @(negedge clk);
        @(negedge clk);
        idle();
        wv = 2'b01; wbr = 2'b01; wt[0] = 4'd1; wr[0] = 32'hAA; wj[0] = 32'h100;
        @(negedge clk);
        idle();
        chk("flushA_redirect_valid", 64'(redir), 64'd1);
        chk("flushA_redirect_pc", 64'(rpc), 64'h100);
        chk("flushA_count", 64'(cnt), 64'd2);
        chk("flushA_alloc_tag0", 64'(tag0), 64'd2);
        chk("flushA_commit_valid", 64'(cv), 64'd0);
        wv = 2'b11; wt[0] = 4'd2; wr[0] = 32'h77; wt[1] = 4'd0; wr[1] = 32'h55;
        @(negedge clk);
        idle();
        chk("flushA_redirect_once", 64'(redir), 64'd0);
        chk("flushA_commit_valid2", 64'(cv), 64'd3);
        chk("flushA_commit_value0", 64'(cval0), 64'h55);
        chk("flushA_commit_value1", 64'(cval1), 64'hAA);
        @(negedge clk);
        chk("flushA_drained_count", 64'(cnt), 64'd0);
        chk("flushA_squashed_entry", 64'(cv), 64'd0);

        // Dual flush: older branch (tag 1) beats tag 3.
        do_reset();
        av = 2'b11;
        @(negedge clk);
        @(negedge clk);
        idle();
        wv = 2'b11; wbr = 2'b11;
        wt[0] = 4'd3; wj[0] = 32'h300;
        wt[1] = 4'd1; wj[1] = 32'h100;
        @(negedge clk);
        idle();
        chk("flushB_redirect_valid", 64'(redir), 64'd1);
        chk("flushB_redirect_pc", 64'(rpc), 64'h100);
        chk("flushB_alloc_tag0", 64'(tag0), 64'd2);
        chk("flushB_count", 64'(cnt), 64'd2);

        // Asynchronous reset with five pending entries, two retireable.
        do_reset();
        ard[0] = 5'd9;
        ard[1] = 5'd10;
        av = 2'b11;
        @(negedge clk);
        @(negedge clk);
        av = 2'b01;
        @(negedge clk);
        idle();
        wv = 2'b11; wt[0] = 4'd0; wt[1] = 4'd1; wr[0] = 32'h1; wr[1] = 32'h2;
        @(negedge clk);
        idle();
        chk("prerst_count", 64'(cnt), 64'd5);
        chk("prerst_commit_valid", 64'(cv), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 64'(cnt), 64'd0);
        chk("rst_commit_valid", 64'(cv), 64'd0);
        chk("rst_alloc_ready", 64'(ready), 64'd1);
        chk("rst_redirect_valid", 64'(redir), 64'd0);
        chk("rst_flooded", 64'(flood), 64'd0);
        chk("rst_alloc_tag0", 64'(tag0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_commit_valid", 64'(cv), 64'd0);
        chk("postrst_count", 64'(cnt), 64'd0);
        chk("postrst_redirect_valid", 64'(redir), 64'd0);

        // Random traffic against the queue model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            check_state();
            rand_drive();
            model_step();
            @(negedge clk);
        end
        check_state();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
